// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-ported data memory between the MEM stage (cpu) and the
//   debug/program loader (dbg). One access is issued per grant. Reads are
//   sequenced over a fixed DM latency, and the read data goes back to the
//   requester that owns the read. A stall is raised toward the pipeline while
//   the MEM-stage access has not completed.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   cpu_req_i/wen_i/addr_i/wdata_i   MEM-stage request (held until cpu_gnt_o)
//   cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o   cpu responses
//   dbg_req_i/wen_i/addr_i/wdata_i   loader request (held until dbg_gnt_o)
//   dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o                 loader responses
//   dm_addr_o, dm_wen_o, dm_wdata_o, dm_rdata_i          data-memory side
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_wen_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_wen_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic              dm_wen_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic [DATA_W-1:0] dm_rdata_i
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 1) : '0;
  localparam int STK_W = $clog2(MAX_CPU_BURST + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_CPU_BURST);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_win, dbg_win, burst_full;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    streak_d    = streak_q;
    raddr_d     = raddr_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_gnt_o    = 1'b0;
    dbg_gnt_o    = 1'b0;
    cpu_rvalid_o = 1'b0;
    dbg_rvalid_o = 1'b0;
    dm_addr_o    = '0;
    dm_wen_o     = 1'b0;
    dm_wdata_o   = '0;
    cpu_win      = 1'b0;
    dbg_win      = 1'b0;
    burst_full   = (streak_q == STK_MAX);

    // Outputs are combinational, so they are forced quiet while reset is held.
    if (rst) begin
      case (state_q)
        IDLE: begin
          // cpu wins ties until it has used up its burst allowance against a
          // waiting loader.
          cpu_win = cpu_req_i & ~(dbg_req_i & burst_full);
          dbg_win = dbg_req_i & ~cpu_win;
          if (cpu_win) begin
            cpu_gnt_o  = 1'b1;
            dm_addr_o  = cpu_addr_i;
            dm_wen_o   = cpu_wen_i;
            dm_wdata_o = cpu_wdata_i;
            if (!cpu_wen_i) begin
              if (RD_LAT == 0) begin
                cpu_rvalid_o = 1'b1;
              end else begin
                state_d   = RD_WAIT;
                owner_d   = OWN_CPU;
                lat_cnt_d = LAT_INIT;
                raddr_d   = cpu_addr_i;
              end
            end
          end else if (dbg_win) begin
            dbg_gnt_o  = 1'b1;
            dm_addr_o  = dbg_addr_i;
            dm_wen_o   = dbg_wen_i;
            dm_wdata_o = dbg_wdata_i;
            if (!dbg_wen_i) begin
              if (RD_LAT == 0) begin
                dbg_rvalid_o = 1'b1;
              end else begin
                state_d   = RD_WAIT;
                owner_d   = OWN_DBG;
                lat_cnt_d = LAT_INIT;
                raddr_d   = dbg_addr_i;
              end
            end
          end
        end
        RD_WAIT: begin
          // Hold the read address on the DM until the data is due.
          dm_addr_o = raddr_q;
          if (lat_cnt_q == '0) begin
            cpu_rvalid_o = (owner_q == OWN_CPU);
            dbg_rvalid_o = (owner_q == OWN_DBG);
            state_d      = IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (!dbg_req_i || dbg_gnt_o) begin
        streak_d = '0;
      end else if (cpu_gnt_o && !burst_full) begin
        streak_d = streak_q + STK_W'(1);
      end

      if (cpu_rvalid_o) cpu_rdata_d = dm_rdata_i;
      if (dbg_rvalid_o) dbg_rdata_d = dm_rdata_i;
    end
  end

  // Read data passes straight through on the delivery cycle and is held
  // afterwards.
  assign cpu_rdata_o = cpu_rvalid_o ? dm_rdata_i : cpu_rdata_q;
  assign dbg_rdata_o = dbg_rvalid_o ? dm_rdata_i : dbg_rdata_q;

  // The MEM access is complete on a write grant or on read-data delivery.
  assign cpu_stall_o = rst & cpu_req_i & ~((cpu_gnt_o & cpu_wen_i) | cpu_rvalid_o);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lat_cnt_q   <= '0;
      streak_q    <= '0;
      raddr_q     <= '0;
      // NOTE: the read-data holding registers are reset too, because their
      // contents are visible on the rdata outputs straight out of reset.
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      streak_q    <= streak_d;
      raddr_q     <= raddr_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Instance dut uses RD_LAT=1 with a
//   registered-read memory model, and instance dut0 uses RD_LAT=0 with a
//   combinational-read model. The stimulus pushes the expected grants and read
//   data into queues. Monitors pop these queues and compare them whenever a
//   grant or rvalid appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct packed {
    logic          is_dbg;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT=1 instance signals
  logic          cpu_req, cpu_wen, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_wen, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] dm_addr;
  logic          dm_wen;
  logic [DW-1:0] dm_wdata, dm_rdata;

  // RD_LAT=0 instance signals
  logic          z_cpu_req, z_cpu_wen, z_cpu_gnt, z_cpu_rvalid, z_cpu_stall;
  logic [AW-1:0] z_cpu_addr;
  logic [DW-1:0] z_cpu_wdata, z_cpu_rdata;
  logic          z_dbg_req, z_dbg_wen, z_dbg_gnt, z_dbg_rvalid;
  logic [AW-1:0] z_dbg_addr;
  logic [DW-1:0] z_dbg_wdata, z_dbg_rdata;
  logic [AW-1:0] z_dm_addr;
  logic          z_dm_wen;
  logic [DW-1:0] z_dm_wdata, z_dm_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_CPU_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_wen_i(dbg_wen), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o(dbg_rdata),
    .dm_addr_o(dm_addr), .dm_wen_o(dm_wen), .dm_wdata_o(dm_wdata),
    .dm_rdata_i(dm_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(0), .MAX_CPU_BURST(4)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req_i(z_cpu_req), .cpu_wen_i(z_cpu_wen), .cpu_addr_i(z_cpu_addr),
    .cpu_wdata_i(z_cpu_wdata), .cpu_gnt_o(z_cpu_gnt), .cpu_rvalid_o(z_cpu_rvalid),
    .cpu_rdata_o(z_cpu_rdata), .cpu_stall_o(z_cpu_stall),
    .dbg_req_i(z_dbg_req), .dbg_wen_i(z_dbg_wen), .dbg_addr_i(z_dbg_addr),
    .dbg_wdata_i(z_dbg_wdata), .dbg_gnt_o(z_dbg_gnt), .dbg_rvalid_o(z_dbg_rvalid),
    .dbg_rdata_o(z_dbg_rdata),
    .dm_addr_o(z_dm_addr), .dm_wen_o(z_dm_wen), .dm_wdata_o(z_dm_wdata),
    .dm_rdata_i(z_dm_rdata)
  );

  // Memory models: registered read (latency 1) and combinational read.
  logic [DW-1:0] mem   [0:1023];
  logic [DW-1:0] z_mem [0:1023];

  always @(posedge clk) begin
    if (dm_wen) mem[dm_addr[9:0]] <= dm_wdata;
    dm_rdata <= mem[dm_addr[9:0]];
  end

  always @(posedge clk) begin
    if (z_dm_wen) z_mem[z_dm_addr[9:0]] <= z_dm_wdata;
  end
  assign z_dm_rdata = z_mem[z_dm_addr[9:0]];

  // Scoreboard
  gnt_t          exp_gnt[$];
  logic [DW-1:0] exp_cpu_rd[$];
  logic [DW-1:0] exp_dbg_rd[$];
  logic [DW-1:0] z_exp_rd[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=present required=none (t=%0t)", name, $time);
  endtask

  function automatic gnt_t mk_gnt(input logic d, input logic w,
                                  input logic [AW-1:0] a, input logic [DW-1:0] wd);
    gnt_t g;
    g.is_dbg = d;
    g.wen    = w;
    g.addr   = a;
    g.wdata  = wd;
    return g;
  endfunction

  function automatic logic [DW-1:0] cdata(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [DW-1:0] ddata(input logic [AW-1:0] a);
    return {16'hD8D8, a};
  endfunction

  // Monitor for the RD_LAT=1 instance
  always @(negedge clk) begin : mon
    gnt_t act;
    if (rst) begin
      if (cpu_gnt || dbg_gnt) begin
        check("gnt_both", {63'd0, cpu_gnt & dbg_gnt}, 64'd0);
        act = mk_gnt(dbg_gnt, dm_wen, dm_addr, dm_wdata);
        if (exp_gnt.size() == 0) unexpected("grant");
        else check("grant", 64'(act), 64'(exp_gnt.pop_front()));
      end
      if (cpu_rvalid) begin
        if (exp_cpu_rd.size() == 0) unexpected("cpu_rvalid");
        else check("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rd.pop_front()));
      end
      if (dbg_rvalid) begin
        if (exp_dbg_rd.size() == 0) unexpected("dbg_rvalid");
        else check("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rd.pop_front()));
      end
    end
  end

  // Monitor for the RD_LAT=0 instance
  always @(negedge clk) begin
    if (rst && z_cpu_rvalid) begin
      if (z_exp_rd.size() == 0) unexpected("z_cpu_rvalid");
      else check("z_cpu_rdata", 64'(z_cpu_rdata), 64'(z_exp_rd.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both requesters issue writes continuously. Each one advances to its next
  // address only after it has seen its own grant.
  task automatic drive_both(input int cycles, input logic [AW-1:0] cbase,
                            input logic [AW-1:0] dbase);
    int ci = 0;
    int di = 0;
    for (int i = 0; i < cycles; i++) begin
      cpu_req = 1'b1; cpu_wen = 1'b1;
      cpu_addr = cbase + AW'(ci); cpu_wdata = cdata(cbase + AW'(ci));
      dbg_req = 1'b1; dbg_wen = 1'b1;
      dbg_addr = dbase + AW'(di); dbg_wdata = ddata(dbase + AW'(di));
      @(negedge clk);
      if (cpu_gnt) ci++;
      if (dbg_gnt) di++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ci, di;
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    dbg_req = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    z_cpu_req = 1'b0; z_cpu_wen = 1'b0; z_cpu_addr = '0; z_cpu_wdata = '0;
    z_dbg_req = 1'b0; z_dbg_wen = 1'b0; z_dbg_addr = '0; z_dbg_wdata = '0;

    // Reset state: a pending cpu request must not leak through.
    repeat (2) @(negedge clk);
    check("rst_cpu_gnt",   64'(cpu_gnt), 64'd0);
    check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    check("rst_dm_wen",    64'(dm_wen), 64'd0);
    check("rst_dm_addr",   64'(dm_addr), 64'd0);
    check("rst_dm_wdata",  64'(dm_wdata), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);

    // T1: cpu write 0x0010 <- 0xDEADBEEF right after release.
    exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("t1_gnt",   64'(cpu_gnt), 64'd1);
    check("t1_dm_wen", 64'(dm_wen), 64'd1);
    check("t1_stall", 64'(cpu_stall), 64'd0);

    // T2: cpu read 0x0010 back, one-cycle latency.
    step();
    cpu_wen = 1'b0; cpu_wdata = '0;
    exp_gnt.push_back(mk_gnt(1'b0, 1'b0, 16'h0010, 32'h0));
    exp_cpu_rd.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("t2_gnt_n",   64'(cpu_gnt), 64'd1);
    check("t2_stall_n", 64'(cpu_stall), 64'd1);
    check("t2_rvalid_n", 64'(cpu_rvalid), 64'd0);
    step();
    @(negedge clk);
    check("t2_rvalid_n1", 64'(cpu_rvalid), 64'd1);
    check("t2_stall_n1",  64'(cpu_stall), 64'd0);
    check("t2_gnt_n1",    64'(cpu_gnt), 64'd0);
    step();
    cpu_req = 1'b0;

    // T3: both write continuously; expect cpu x4, dbg x1, repeating.
    ci = 0; di = 0;
    for (int g = 0; g < 10; g++) begin
      if ((g % 5) == 4) begin
        exp_gnt.push_back(mk_gnt(1'b1, 1'b1, 16'h0100 + AW'(di), ddata(16'h0100 + AW'(di))));
        di++;
      end else begin
        exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0020 + AW'(ci), cdata(16'h0020 + AW'(ci))));
        ci++;
      end
    end
    drive_both(10, 16'h0020, 16'h0100);
    cpu_req = 1'b0;

    // T4: dbg read in flight, cpu write arrives during RD_WAIT.
    dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 16'h0100; dbg_wdata = '0;
    exp_gnt.push_back(mk_gnt(1'b1, 1'b0, 16'h0100, 32'h0));
    exp_dbg_rd.push_back(32'hD8D8_0100);
    exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0030, 32'h12345678));
    @(negedge clk);
    check("t4_dbg_gnt", 64'(dbg_gnt), 64'd1);
    step();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h12345678;
    @(negedge clk);
    check("t4_cpu_gnt_wait", 64'(cpu_gnt), 64'd0);
    check("t4_stall_wait",   64'(cpu_stall), 64'd1);
    check("t4_dbg_rvalid",   64'(dbg_rvalid), 64'd1);
    step();
    @(negedge clk);
    check("t4_cpu_gnt_next", 64'(cpu_gnt), 64'd1);
    check("t4_stall_next",   64'(cpu_stall), 64'd0);
    step();
    // Read the word back so the cpu rdata register holds a known value.
    cpu_wen = 1'b0; cpu_wdata = '0;
    exp_gnt.push_back(mk_gnt(1'b0, 1'b0, 16'h0030, 32'h0));
    exp_cpu_rd.push_back(32'h12345678);
    @(negedge clk);
    check("t4_rd_stall", 64'(cpu_stall), 64'd1);
    step();
    @(negedge clk);
    check("t4_rd_stall_done", 64'(cpu_stall), 64'd0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("hold_cpu_rdata", 64'(cpu_rdata), 64'(32'h12345678));
    check("hold_dbg_rdata", 64'(dbg_rdata), 64'(32'hD8D8_0100));
    step();

    // T5: build up a cpu streak with dbg waiting, start a cpu read, and
    // reset in the middle of the read.
    exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0040, cdata(16'h0040)));
    exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0041, cdata(16'h0041)));
    drive_both(2, 16'h0040, 16'h0200);
    cpu_wen = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
    exp_gnt.push_back(mk_gnt(1'b0, 1'b0, 16'h0010, 32'h0));
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("t5_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("t5_dbg_gnt",    64'(dbg_gnt), 64'd0);
    check("t5_dm_addr",    64'(dm_addr), 64'd0);
    check("t5_stall",      64'(cpu_stall), 64'd0);
    check("t5_cpu_rdata",  64'(cpu_rdata), 64'd0);
    check("t5_dbg_rdata",  64'(dbg_rdata), 64'd0);
    @(negedge clk);
    check("t5_rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("t5_rst_dbg_gnt", 64'(dbg_gnt), 64'd0);
    step();
    rst = 1'b1;
    // A cleared streak means the cpu gets a full burst of four again.
    for (int k = 0; k < 4; k++)
      exp_gnt.push_back(mk_gnt(1'b0, 1'b1, 16'h0050 + AW'(k), cdata(16'h0050 + AW'(k))));
    exp_gnt.push_back(mk_gnt(1'b1, 1'b1, 16'h0200, ddata(16'h0200)));
    drive_both(5, 16'h0050, 16'h0200);
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) step();

    // T6: RD_LAT=0 instance, back-to-back writes then back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      z_cpu_req = 1'b1; z_cpu_wen = 1'b1;
      z_cpu_addr = 16'h0010 + AW'(i); z_cpu_wdata = 32'hA5A5_0000 + DW'(i);
      @(negedge clk);
      check("t6_wr_gnt",   64'(z_cpu_gnt), 64'd1);
      check("t6_wr_stall", 64'(z_cpu_stall), 64'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      z_cpu_req = 1'b1; z_cpu_wen = 1'b0;
      z_cpu_addr = 16'h0010 + AW'(i); z_cpu_wdata = '0;
      z_exp_rd.push_back(32'hA5A5_0000 + DW'(i));
      @(negedge clk);
      check("t6_rd_gnt",    64'(z_cpu_gnt), 64'd1);
      check("t6_rd_rvalid", 64'(z_cpu_rvalid), 64'd1);
      check("t6_rd_stall",  64'(z_cpu_stall), 64'd0);
      step();
    end
    z_cpu_req = 1'b0;
    repeat (2) step();

    check("exp_gnt_drained",    64'(exp_gnt.size()), 64'd0);
    check("exp_cpu_rd_drained", 64'(exp_cpu_rd.size()), 64'd0);
    check("exp_dbg_rd_drained", 64'(exp_dbg_rd.size()), 64'd0);
    check("z_exp_rd_drained",   64'(z_exp_rd.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
